// File: rtl/button_led_ctrl.sv
// Multi-channel push-button front end: 2-FF sync, debounce FSM, LED drive.
// Each channel runs in toggle or momentary mode and emits a press strobe.
module button_led_ctrl #(
    parameter int N_CH            = 4,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn,
    input  logic [N_CH-1:0] mode,
    input  logic            led_clr,
    output logic [N_CH-1:0] LED,
    output logic [N_CH-1:0] btn_db,
    output logic [N_CH-1:0] press_pulse
);

    localparam int CNT_W =
        (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DEB_PRESS,
        PRESSED,
        DEB_RELEASE
    } state_t;

    logic [N_CH-1:0] s1;
    logic [N_CH-1:0] s2;

    // Two-flop synchroniser for the raw asynchronous buttons
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= btn;
            s2 <= s1;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        state_t           state;
        logic [CNT_W-1:0] cnt;
        logic             db_q;
        logic             pulse_q;
        logic             led_q;
        logic             done;
        logic             press_now;
        logic             rel_now;
        logic             db_next;

        assign done = (cnt == CNT_LAST);

        // Debounced level as it will be after this edge; lets
        // momentary-mode LED track btn_db in the same cycle
        always_comb begin
            press_now = (state == DEB_PRESS) && s2[i] && done;
            rel_now   = (state == DEB_RELEASE) && !s2[i] && done;
            db_next   = db_q;
            if (press_now) begin
                db_next = 1'b1;
            end else if (rel_now) begin
                db_next = 1'b0;
            end
        end

        // Debounce FSM: a level must hold for the full count
        always_ff @(posedge clk) begin
            if (rst) begin
                state   <= IDLE;
                cnt     <= '0;
                db_q    <= 1'b0;
                pulse_q <= 1'b0;
            end else begin
                pulse_q <= 1'b0;
                unique case (state)
                    IDLE: begin
                        if (s2[i]) begin
                            state <= DEB_PRESS;
                            cnt   <= '0;
                        end
                    end
                    DEB_PRESS: begin
                        if (!s2[i]) begin
                            state <= IDLE;
                        end else if (done) begin
                            state   <= PRESSED;
                            db_q    <= 1'b1;
                            pulse_q <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    PRESSED: begin
                        if (!s2[i]) begin
                            state <= DEB_RELEASE;
                            cnt   <= '0;
                        end
                    end
                    DEB_RELEASE: begin
                        if (s2[i]) begin
                            state <= PRESSED;
                        end else if (done) begin
                            state <= IDLE;
                            db_q  <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end

        // LED drive: clear wins, then momentary follow, then toggle
        always_ff @(posedge clk) begin
            if (rst) begin
                led_q <= 1'b0;
            end else if (led_clr) begin
                led_q <= 1'b0;
            end else if (mode[i]) begin
                led_q <= db_next;
            end else if (press_now) begin
                led_q <= ~led_q;
            end
        end

        assign LED[i]         = led_q;
        assign btn_db[i]      = db_q;
        assign press_pulse[i] = pulse_q;
    end

endmodule

// File: tb/tb_button_led_ctrl.sv
// Scoreboard bench for button_led_ctrl (2 channels, 4-cycle debounce).
// Expected per-edge outputs are queued by the driver, popped by a monitor.
module tb_button_led_ctrl;

    localparam int DEB = 4;

    logic       clk;
    logic       rst;
    logic [1:0] btn;
    logic [1:0] mode;
    logic       led_clr;
    logic [1:0] LED;
    logic [1:0] btn_db;
    logic [1:0] press_pulse;

    int errors = 0;
    int checks = 0;
    int pulse0 = 0;

    logic [5:0] q[$];

    int run[2];
    bit db_m[2];
    bit led_m[2];
    bit pl_m[2];
    bit s1m[2];
    bit s2m[2];

    button_led_ctrl #(
        .N_CH(2),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn(btn),
        .mode(mode),
        .led_clr(led_clr),
        .LED(LED),
        .btn_db(btn_db),
        .press_pulse(press_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [1:0] act,
                       input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Reference: a debounced level flips once the synchronised input
    // has disagreed with it for DEB+1 consecutive edges.
    task automatic step(input logic [1:0] b, input logic [1:0] m,
                        input logic c, input logic r);
        @(negedge clk);
        btn = b;
        mode = m;
        led_clr = c;
        rst = r;
        for (int ch = 0; ch < 2; ch++) begin
            if (r) begin
                run[ch] = 0;
                db_m[ch] = 0;
                led_m[ch] = 0;
                pl_m[ch] = 0;
                s1m[ch] = 0;
                s2m[ch] = 0;
            end else begin
                pl_m[ch] = 0;
                if (s2m[ch] != db_m[ch]) begin
                    run[ch]++;
                    if (run[ch] == DEB + 1) begin
                        db_m[ch] = ~db_m[ch];
                        run[ch] = 0;
                        pl_m[ch] = db_m[ch];
                    end
                end else begin
                    run[ch] = 0;
                end
                if (c) led_m[ch] = 0;
                else if (m[ch]) led_m[ch] = db_m[ch];
                else if (pl_m[ch]) led_m[ch] = ~led_m[ch];
                s2m[ch] = s1m[ch];
                s1m[ch] = b[ch];
            end
        end
        q.push_back({led_m[1], led_m[0], db_m[1], db_m[0],
                     pl_m[1], pl_m[0]});
    endtask

    // Wait until just after the edge the last step was issued for
    task automatic settle();
        #7;
    endtask

    // Monitor: compare DUT outputs against queued expectations
    initial begin
        logic [5:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (press_pulse[0]) pulse0++;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("led", LED, e[5:4]);
                chk("btn_db", btn_db, e[3:2]);
                chk("pulse", press_pulse, e[1:0]);
            end
        end
    end

    initial begin
        int p;
        int w;
        logic [1:0] rb;
        logic [1:0] rm;
        btn = 0;
        mode = 0;
        led_clr = 0;
        rst = 1;
        step(2'b00, 2'b00, 0, 1);
        step(2'b00, 2'b00, 0, 1);
        settle();
        chk("reset_outs", LED | btn_db | press_pulse, 2'b00);

        // Clean press: pulse and LED on edge 7 only
        p = pulse0;
        for (int k = 1; k <= 20; k++) begin
            step(2'b01, 2'b00, 0, 0);
            settle();
            if (k <= 10) begin
                chk("s1_pulse", {1'b0, press_pulse[0]},
                    {1'b0, k == 7});
                chk("s1_led", {1'b0, LED[0]}, {1'b0, k >= 7});
            end
        end
        for (int k = 1; k <= 12; k++) begin
            step(2'b00, 2'b00, 0, 0);
            settle();
            chk("s1_release", {1'b0, btn_db[0]}, {1'b0, k < 7});
        end
        chk("s1_npulse", 2'(pulse0 - p), 2'd1);

        // Bounce then stable press: one pulse
        p = pulse0;
        for (int k = 0; k < 3; k++) step(2'b01, 2'b00, 0, 0);
        step(2'b00, 2'b00, 0, 0);
        for (int k = 0; k < 12; k++) step(2'b01, 2'b00, 0, 0);
        for (int k = 0; k < 12; k++) step(2'b00, 2'b00, 0, 0);
        settle();
        chk("s2_npulse", 2'(pulse0 - p), 2'd1);
        chk("s2_led", {1'b0, LED[0]}, 2'b00);

        // Two full press/release cycles
        p = pulse0;
        for (int n = 0; n < 2; n++) begin
            for (int k = 0; k < 10; k++) step(2'b01, 2'b00, 0, 0);
            for (int k = 0; k < 10; k++) step(2'b00, 2'b00, 0, 0);
        end
        settle();
        chk("s3_npulse", 2'(pulse0 - p), 2'd2);

        // Momentary on channel 1
        for (int k = 1; k <= 20; k++) begin
            step((k <= 10) ? 2'b10 : 2'b00, 2'b10, 0, 0);
            settle();
            chk("s4_follow", {1'b0, LED[1]}, {1'b0, btn_db[1]});
            chk("s4_led", {1'b0, LED[1]},
                {1'b0, (k >= 7) && (k < 17)});
        end

        // Get LED[0]=1, then clear on the confirming edge
        for (int k = 0; k < 10; k++) step(2'b01, 2'b00, 0, 0);
        for (int k = 0; k < 10; k++) step(2'b00, 2'b00, 0, 0);
        settle();
        chk("s5_pre", {1'b0, LED[0]}, 2'b01);
        for (int k = 1; k <= 10; k++) begin
            step(2'b01, 2'b00, k == 7, 0);
            settle();
            if (k == 7) begin
                chk("s5_led", {1'b0, LED[0]}, 2'b00);
                chk("s5_pulse", {1'b0, press_pulse[0]}, 2'b01);
            end
        end
        for (int k = 0; k < 10; k++) step(2'b00, 2'b00, 0, 0);

        // Reset mid-debounce with the button still held
        for (int k = 0; k < 5; k++) step(2'b01, 2'b00, 0, 0);
        step(2'b01, 2'b00, 0, 1);
        settle();
        chk("s6_rst", LED | btn_db | press_pulse, 2'b00);
        for (int k = 1; k <= 10; k++) begin
            step(2'b01, 2'b00, 0, 0);
            settle();
            chk("s6_pulse", {1'b0, press_pulse[0]},
                {1'b0, k == 7});
        end
        for (int k = 0; k < 10; k++) step(2'b00, 2'b00, 0, 0);

        // Random bouncy buttons, mode flips, clears, resets
        rb = 0;
        rm = 0;
        for (int k = 0; k < 3000; k++) begin
            for (int ch = 0; ch < 2; ch++) begin
                if ($urandom_range(7) == 0) rb[ch] = ~rb[ch];
                if ($urandom_range(49) == 0) rm[ch] = ~rm[ch];
            end
            step(rb, rm, $urandom_range(39) == 0,
                 $urandom_range(299) == 0);
        end

        w = 0;
        while (q.size() > 0 && w < 10) begin
            @(posedge clk);
            w++;
        end
        #3;
        chk("drain", 2'(q.size() != 0), 2'b00);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
